regs_ctrl: RTL and testbench

Sequencer and arbiter in front of the CPU register file (`regs`, 32×32, two registered read ports, one write port, 1-cycle read latency). After reset it zero-clears x1..x31 in hardware, then shares the ports between the pipeline (decode reads, writeback write) and a single-word debug/loader port. It also adds write-to-read bypass, so the pipeline always sees the newest value.

---
 rtl/regs_ctrl_pkg.sv | 25 ++
 rtl/regs_bypass.sv | 33 +++
 rtl/regs_ctrl.sv | 129 ++++++++++++
 tb/tb_regs_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_ctrl_pkg.sv
// Shared definitions for the register-file controller: FSM encoding,
// clear-sequence bounds and the write/read hit helper used by the bypass.
package regs_ctrl_pkg;

  localparam int RC_AW = 5;
  localparam int RC_DW = 32;

  typedef enum logic [1:0] {
    RC_CLEAR = 2'd0,
    RC_RUN   = 2'd1,
    RC_DBG   = 2'd2,
    RC_ACK   = 2'd3
  } rc_state_e;

  localparam logic [RC_AW-1:0] RC_CLEAR_FIRST = 5'd1;
  localparam logic [RC_AW-1:0] RC_CLEAR_LAST  = 5'd31;

  // x0 is hardwired in the register file, so a write to it never forwards.
  function automatic logic wr_hit(input logic ce, input logic we,
                                  input logic [RC_AW-1:0] wr_addr,
                                  input logic [RC_AW-1:0] rd_addr);
    return ce && we && (wr_addr != '0) && (wr_addr == rd_addr);
  endfunction

endpackage

// File: rtl/regs_bypass.sv
// One read port's write-to-read forwarding: remembers a same-cycle write to
// the address being read and substitutes it for the (stale) file output.
module regs_bypass
  import regs_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             we,
  input  logic [RC_AW-1:0] wr_addr,
  input  logic [RC_DW-1:0] wr_dat,
  input  logic [RC_AW-1:0] rd_addr,
  input  logic [RC_DW-1:0] file_dat,
  output logic [RC_DW-1:0] dat
);

  logic             hit;
  logic [RC_DW-1:0] cap;

  // Follows the file's own read register: only updates when the file does.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit <= 1'b0;
      cap <= '0;
    end else if (ce) begin
      hit <= wr_hit(ce, we, wr_addr, rd_addr);
      cap <= wr_dat;
    end
  end

  assign dat = hit ? cap : file_dat;

endmodule

// File: rtl/regs_ctrl.sv
// Register-file sequencer: hardware clear after reset, then arbitration
// between the pipeline and a single-word debug port, plus read bypass.
module regs_ctrl
  import regs_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic [RC_AW-1:0] i_rd_addr_a,
  input  logic [RC_AW-1:0] i_rd_addr_b,
  input  logic             i_wb_we,
  input  logic [RC_AW-1:0] i_wb_addr,
  input  logic [RC_DW-1:0] i_wb_dat,
  output logic [RC_DW-1:0] o_dat_rd_a,
  output logic [RC_DW-1:0] o_dat_rd_b,
  output logic             o_stall,
  input  logic             i_dbg_req,
  input  logic             i_dbg_we,
  input  logic [RC_AW-1:0] i_dbg_addr,
  input  logic [RC_DW-1:0] i_dbg_dat,
  output logic             o_dbg_ack,
  output logic [RC_DW-1:0] o_dbg_dat,
  output logic             o_regs_ce,
  output logic             o_regs_we,
  output logic [RC_AW-1:0] o_regs_addr_rd_a,
  output logic [RC_AW-1:0] o_regs_addr_rd_b,
  output logic [RC_AW-1:0] o_regs_addr_wr,
  output logic [RC_DW-1:0] o_regs_dat_wr,
  input  logic [RC_DW-1:0] i_regs_dat_a,
  input  logic [RC_DW-1:0] i_regs_dat_b
);

  rc_state_e        state;
  logic [RC_AW-1:0] clr_cnt;
  logic [RC_DW-1:0] dbg_dat_q;
  logic             ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= RC_CLEAR;
      clr_cnt   <= RC_CLEAR_FIRST;
      dbg_dat_q <= '0;
    end else begin
      case (state)
        RC_CLEAR: begin
          if (clr_cnt == RC_CLEAR_LAST) state <= RC_RUN;
          else                          clr_cnt <= clr_cnt + 5'd1;
        end
        RC_RUN: begin
          if (i_dbg_req) state <= RC_DBG;
        end
        RC_DBG: state <= RC_ACK;
        RC_ACK: begin
          dbg_dat_q <= i_regs_dat_a;
          state     <= RC_RUN;
        end
        default: state <= RC_CLEAR;
      endcase
    end
  end

  // Port steering. While reset is held the outputs already look like the
  // first clear cycle, whatever state the FSM was left in.
  always_comb begin
    o_regs_ce        = 1'b1;
    o_regs_we        = 1'b0;
    o_regs_addr_rd_a = i_rd_addr_a;
    o_regs_addr_rd_b = i_rd_addr_b;
    o_regs_addr_wr   = i_wb_addr;
    o_regs_dat_wr    = i_wb_dat;
    o_stall          = 1'b1;
    ack              = 1'b0;
    if (i_rst) begin
      o_regs_we      = 1'b1;
      o_regs_addr_wr = RC_CLEAR_FIRST;
      o_regs_dat_wr  = '0;
    end else begin
      case (state)
        RC_CLEAR: begin
          o_regs_we      = 1'b1;
          o_regs_addr_wr = clr_cnt;
          o_regs_dat_wr  = '0;
        end
        RC_RUN: begin
          o_regs_ce = i_ce;
          o_regs_we = i_wb_we;
          o_stall   = i_dbg_req;
        end
        RC_DBG: begin
          o_regs_addr_rd_a = i_dbg_addr;
          o_regs_we        = i_dbg_we;
          o_regs_addr_wr   = i_dbg_addr;
          o_regs_dat_wr    = i_dbg_dat;
        end
        RC_ACK: ack = 1'b1;
        default: ;
      endcase
    end
  end

  // The file read issued in DBG lands here, before that cycle's write.
  assign o_dbg_ack = ack;
  assign o_dbg_dat = ack ? i_regs_dat_a : dbg_dat_q;

  regs_bypass u_bypass_a (
    .clk      (i_clk),
    .rst      (i_rst),
    .ce       (o_regs_ce),
    .we       (o_regs_we),
    .wr_addr  (o_regs_addr_wr),
    .wr_dat   (o_regs_dat_wr),
    .rd_addr  (o_regs_addr_rd_a),
    .file_dat (i_regs_dat_a),
    .dat      (o_dat_rd_a)
  );

  regs_bypass u_bypass_b (
    .clk      (i_clk),
    .rst      (i_rst),
    .ce       (o_regs_ce),
    .we       (o_regs_we),
    .wr_addr  (o_regs_addr_wr),
    .wr_dat   (o_regs_dat_wr),
    .rd_addr  (o_regs_addr_rd_b),
    .file_dat (i_regs_dat_b),
    .dat      (o_dat_rd_b)
  );

endmodule

// File: tb/tb_regs_ctrl.sv
// Bench for regs_ctrl: behavioural 32x32 register file, reference register
// image, expected-value queues for pipeline reads and debug acks.
module tb_regs_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic [4:0]  rd_addr_a = '0, rd_addr_b = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_dat = '0;
  logic [31:0] dat_rd_a, dat_rd_b;
  logic        stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdat = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdat;
  logic        regs_ce, regs_we;
  logic [4:0]  regs_addr_rd_a, regs_addr_rd_b, regs_addr_wr;
  logic [31:0] regs_dat_wr;
  logic [31:0] regs_dat_a, regs_dat_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] dbg_exp_q[$];
  logic [31:0] exp_mem[32];

  // clock / reset
  always #5 clk = ~clk;

  regs_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .i_rd_addr_a(rd_addr_a), .i_rd_addr_b(rd_addr_b),
    .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_dat(wb_dat),
    .o_dat_rd_a(dat_rd_a), .o_dat_rd_b(dat_rd_b), .o_stall(stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
    .i_dbg_dat(dbg_wdat), .o_dbg_ack(dbg_ack), .o_dbg_dat(dbg_rdat),
    .o_regs_ce(regs_ce), .o_regs_we(regs_we),
    .o_regs_addr_rd_a(regs_addr_rd_a), .o_regs_addr_rd_b(regs_addr_rd_b),
    .o_regs_addr_wr(regs_addr_wr), .o_regs_dat_wr(regs_dat_wr),
    .i_regs_dat_a(regs_dat_a), .i_regs_dat_b(regs_dat_b)
  );

  // register file: registered reads (old data on same-address write), x0 fixed
  logic [31:0] mem[32];
  bit          mem_seeded = 1'b0;
  always @(posedge clk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'd0 : ($urandom | 32'd1);
      regs_dat_a <= '0;
      regs_dat_b <= '0;
      mem_seeded <= 1'b1;
    end else if (regs_ce) begin
      regs_dat_a <= mem[regs_addr_rd_a];
      regs_dat_b <= mem[regs_addr_rd_b];
      if (regs_we && regs_addr_wr != 5'd0) mem[regs_addr_wr] <= regs_dat_wr;
    end
  end

  function automatic void check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endfunction

  // scoreboard side for debug completions
  always @(negedge clk) begin
    if (dbg_ack === 1'b1) begin
      if (dbg_exp_q.size() == 0) check("dbg_ack_unexpected", 32'd1, 32'd0);
      else check("dbg_dat", dbg_rdat, dbg_exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 1; i < 32; i++) exp_mem[i] = 32'd0;
  endtask

  task automatic wait_clear(input int exp_cycles);
    int n;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    check("clear_len", 32'(n), 32'(exp_cycles));
    tick();
  endtask

  task automatic pipe_op(input logic [4:0] a, input logic [4:0] b, input logic we,
                         input logic [4:0] waddr, input logic [31:0] wdat);
    logic [31:0] ea, eb;
    ea = (we && waddr != 5'd0 && waddr == a) ? wdat : exp_mem[a];
    eb = (we && waddr != 5'd0 && waddr == b) ? wdat : exp_mem[b];
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    if (we && waddr != 5'd0) exp_mem[waddr] = wdat;
    rd_addr_a = a; rd_addr_b = b;
    wb_we = we; wb_addr = waddr; wb_dat = wdat;
    tick();
    wb_we = 1'b0;
    @(negedge clk);
    check("rd_a", dat_rd_a, exp_q.pop_front());
    check("rd_b", dat_rd_b, exp_q.pop_front());
    tick();
  endtask

  task automatic dbg_access(input logic we, input logic [4:0] addr, input logic [31:0] dat,
                            input logic pw, input logic [4:0] paddr, input logic [31:0] pdat);
    int lat, st;
    logic got;
    if (pw && paddr != 5'd0) exp_mem[paddr] = pdat;
    dbg_exp_q.push_back(exp_mem[addr]);
    if (we && addr != 5'd0) exp_mem[addr] = dat;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdat = dat;
    wb_we = pw; wb_addr = paddr; wb_dat = pdat;
    lat = 0; st = 0; got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (stall) st++;
      if (dbg_ack) begin
        got = 1'b1;
        break;
      end
      lat++;
      tick();
      wb_we = 1'b0;
    end
    check("dbg_ack_seen", 32'(got), 32'd1);
    check("dbg_latency", 32'(lat), 32'd2);
    tick();
    dbg_req = 1'b0;
    wb_we = 1'b0;
    @(negedge clk);
    check("dbg_stall_len", 32'(st), 32'd3);
    check("dbg_stall_after", 32'(stall), 32'd0);
    tick();
  endtask

  task automatic peek_all();
    for (int i = 1; i < 32; i++) dbg_access(1'b0, 5'(i), 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int n;
    logic [4:0] a, w;
    exp_mem[0] = 32'd0;
    for (int i = 1; i < 32; i++) exp_mem[i] = 32'hxxxx_xxxx;

    // reset values
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_ack", 32'(dbg_ack), 32'd0);
    check("rst_dbg_dat", dbg_rdat, 32'd0);
    check("rst_rd_a", dat_rd_a, 32'd0);
    check("rst_rd_b", dat_rd_b, 32'd0);
    check("rst_regs_we", 32'(regs_we), 32'd1);
    check("rst_regs_addr_wr", 32'(regs_addr_wr), 32'd1);
    tick();
    rst = 1'b0;
    clear_model();
    wait_clear(31);
    peek_all();

    // same-cycle bypass and x0 behaviour
    pipe_op(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    pipe_op(5'd0, 5'd5, 1'b1, 5'd0, 32'h00001234);
    pipe_op(5'd5, 5'd5, 1'b0, 5'd0, 32'd0);

    // debug write then pipeline read
    dbg_access(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
    pipe_op(5'd7, 5'd7, 1'b0, 5'd0, 32'd0);
    dbg_access(1'b1, 5'd0, 32'h55555555, 1'b0, 5'd0, 32'd0);
    pipe_op(5'd0, 5'd7, 1'b0, 5'd0, 32'd0);

    // debug request coincident with a pipeline write
    dbg_access(1'b0, 5'd3, 32'd0, 1'b1, 5'd3, 32'h00000011);
    pipe_op(5'd3, 5'd0, 1'b0, 5'd0, 32'd0);
    dbg_access(1'b1, 5'd3, 32'h00000022, 1'b1, 5'd3, 32'h00000033);
    pipe_op(5'd0, 5'd3, 1'b0, 5'd0, 32'd0);

    // random pipeline traffic, biased toward address collisions
    for (int i = 0; i < 24; i++) begin
      a = 5'($urandom_range(0, 31));
      w = ($urandom_range(0, 1) == 1) ? a : 5'($urandom_range(0, 31));
      pipe_op(a, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), w, $urandom);
    end
    dbg_access(1'b0, 5'd5, 32'd0, 1'b0, 5'd0, 32'd0);

    // debug request held through clear is served only after clear
    rst = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
    repeat (3) tick();
    rst = 1'b0;
    clear_model();
    dbg_exp_q.push_back(32'd0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dbg_ack) break;
      n++;
      tick();
    end
    check("clear_req_ack_cycle", 32'(n), 32'd33);
    tick();
    dbg_req = 1'b0;
    pipe_op(5'd5, 5'd7, 1'b1, 5'd9, 32'hCAFEF00D);
    pipe_op(5'd9, 5'd3, 1'b0, 5'd0, 32'd0);

    // reset during DBG drops the access and restarts clear
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdat = 32'hFFFF0000;
    tick();
    rst = 1'b1;
    dbg_req = 1'b0;
    @(negedge clk);
    check("rst_dbg_stall", 32'(stall), 32'd1);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    tick();
    rst = 1'b0;
    clear_model();
    wait_clear(31);
    peek_all();

    check("dbg_q_empty", 32'(dbg_exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
